// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_OPERATING   = 2'd0,
        ST_TRAP_TAKEN  = 2'd1,
        ST_TRAP_RETURN = 2'd2,
        ST_HOLD        = 2'd3
    } trap_state_t;

    localparam logic [4:0] IRQ_MSI        = 5'd3;
    localparam logic [4:0] IRQ_MTI        = 5'd7;
    localparam logic [4:0] IRQ_MEI        = 5'd11;
    localparam logic [4:0] IRQ_LOCAL_BASE = 5'd16;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    localparam int HOLD_CNT_W = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > local interrupts (lowest index first).
module irq_prio_enc
    import trap_pkg::*;
#(
    parameter int IRQ_W = 32
) (
    input  logic [IRQ_W-1:0] ipend,
    output logic             any,
    output logic [4:0]       cause
);

    logic unused_bits;

    // Only 3, 7, 11 and the local range carry interrupts; the rest are architecturally reserved.
    assign unused_bits = ^{ipend[15:12], ipend[10:8], ipend[6:4], ipend[2:0]};

    always_comb begin
        any   = 1'b0;
        cause = 5'd0;
        // Walk downwards so the lowest pending local index is the one left standing.
        for (int i = IRQ_W - 1; i >= int'(IRQ_LOCAL_BASE); i--) begin
            if (ipend[i]) begin
                any   = 1'b1;
                cause = 5'(i);
            end
        end
        if (ipend[IRQ_MTI]) begin
            any   = 1'b1;
            cause = IRQ_MTI;
        end
        if (ipend[IRQ_MSI]) begin
            any   = 1'b1;
            cause = IRQ_MSI;
        end
        if (ipend[IRQ_MEI]) begin
            any   = 1'b1;
            cause = IRQ_MEI;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: takes exceptions, interrupts and mret at the mem stage,
// drives mcause/mepc/mtval writes and a pipeline redirect, then holds off for FLUSH_HOLD cycles.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int  DATA_WIDTH    = 32,
    parameter int  NUM_LOCAL_IRQ = 16,
    parameter int  FLUSH_HOLD    = 2,
    localparam int IRQ_W         = 16 + NUM_LOCAL_IRQ
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  commit_valid_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  exc_valid_i,
    input  logic [3:0]            exc_code_i,
    input  logic [DATA_WIDTH-1:0] exc_tval_i,
    input  logic                  mret_i,
    input  logic                  mstatus_mie_i,
    input  logic [IRQ_W-1:0]      mie_i,
    input  logic [IRQ_W-1:0]      mip_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    input  logic [DATA_WIDTH-1:0] mepc_i,
    output logic                  flush_o,
    output logic [DATA_WIDTH-1:0] new_pc_o,
    output logic                  cause_we_o,
    output logic [DATA_WIDTH-1:0] cause_o,
    output logic                  epc_we_o,
    output logic [DATA_WIDTH-1:0] epc_o,
    output logic                  tval_we_o,
    output logic [DATA_WIDTH-1:0] tval_o,
    output logic                  mstatus_ie_clear_o,
    output logic                  mstatus_ie_set_o,
    output trap_state_t           dbg_state_o
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
        (FLUSH_HOLD == 0) ? '0 : HOLD_CNT_W'(FLUSH_HOLD - 1);

    // commit_valid_i qualifies the mem-stage instruction; there is no back-pressure, so a
    // decision is taken in the very cycle it is valid and nothing is remembered otherwise.

    logic [1:0]              rst_sync_q;
    logic                    rst_n;
    trap_state_t             state_q, state_d;
    logic [HOLD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    latch_exc, latch_irq;
    logic                    irq_any, irq_req;
    logic [4:0]              irq_cause;
    logic [IRQ_W-1:0]        ipend;
    logic [4:0]              cause_q;
    logic                    int_q;
    logic [DATA_WIDTH-1:0]   epc_q, tval_q;
    logic [DATA_WIDTH-1:0]   trap_base, trap_target, ret_target;
    logic                    unused_mepc;

    assign unused_mepc = ^mepc_i[1:0];

    // Assertion is immediate; release is retimed to clk_i through two flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    assign ipend = mie_i & mip_i;

    irq_prio_enc #(
        .IRQ_W (IRQ_W)
    ) u_prio (
        .ipend (ipend),
        .any   (irq_any),
        .cause (irq_cause)
    );

    assign irq_req = mstatus_mie_i & irq_any;

    always_comb begin
        trap_base   = {mtvec_i[DATA_WIDTH-1:2], 2'b00};
        trap_target = trap_base;
        case (mtvec_i[1:0])
            MTVEC_VECTORED: begin
                if (int_q) begin
                    trap_target = trap_base + DATA_WIDTH'({cause_q, 2'b00});
                end
            end
            MTVEC_DIRECT: trap_target = trap_base;
            default:      trap_target = trap_base;
        endcase
        ret_target = {mepc_i[DATA_WIDTH-1:2], 2'b00};
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OPERATING;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        latch_exc          = 1'b0;
        latch_irq          = 1'b0;
        flush_o            = 1'b0;
        new_pc_o           = '0;
        cause_we_o         = 1'b0;
        epc_we_o           = 1'b0;
        tval_we_o          = 1'b0;
        mstatus_ie_clear_o = 1'b0;
        mstatus_ie_set_o   = 1'b0;
        case (state_q)
            ST_OPERATING: begin
                if (commit_valid_i) begin
                    if (exc_valid_i) begin
                        latch_exc = 1'b1;
                        state_d   = ST_TRAP_TAKEN;
                    end else if (irq_req) begin
                        latch_irq = 1'b1;
                        state_d   = ST_TRAP_TAKEN;
                    end else if (mret_i) begin
                        state_d   = ST_TRAP_RETURN;
                    end
                end
            end
            ST_TRAP_TAKEN: begin
                flush_o            = 1'b1;
                new_pc_o           = trap_target;
                cause_we_o         = 1'b1;
                epc_we_o           = 1'b1;
                tval_we_o          = 1'b1;
                mstatus_ie_clear_o = 1'b1;
                if (FLUSH_HOLD == 0) begin
                    state_d = ST_OPERATING;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_TRAP_RETURN: begin
                flush_o          = 1'b1;
                new_pc_o         = ret_target;
                mstatus_ie_set_o = 1'b1;
                if (FLUSH_HOLD == 0) begin
                    state_d = ST_OPERATING;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_OPERATING;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_OPERATING;
                cnt_d   = '0;
            end
        endcase
    end

    // An interrupt records the PC of the instruction it kills, so mret re-executes it.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= '0;
            int_q   <= 1'b0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else if (latch_exc) begin
            cause_q <= {1'b0, exc_code_i};
            int_q   <= 1'b0;
            epc_q   <= pc_i;
            tval_q  <= exc_tval_i;
        end else if (latch_irq) begin
            cause_q <= irq_cause;
            int_q   <= 1'b1;
            epc_q   <= pc_i;
            tval_q  <= '0;
        end
    end

    assign cause_o     = {int_q, {(DATA_WIDTH-6){1'b0}}, cause_q};
    assign epc_o       = epc_q;
    assign tval_o      = tval_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed trap/mret scenarios, a randomised
// back-to-back run and an asynchronous reset in the middle of a trap.
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int DW = 32;
    localparam int NL = 16;
    localparam int FH = 2;
    localparam int IW = 16 + NL;

    typedef struct packed {
        logic          flush;
        logic [DW-1:0] new_pc;
        logic          cause_we;
        logic [DW-1:0] cause;
        logic          epc_we;
        logic [DW-1:0] epc;
        logic          tval_we;
        logic [DW-1:0] tval;
        logic          ie_clear;
        logic          ie_set;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          commit_valid_i;
    logic [DW-1:0] pc_i;
    logic          exc_valid_i;
    logic [3:0]    exc_code_i;
    logic [DW-1:0] exc_tval_i;
    logic          mret_i;
    logic          mstatus_mie_i;
    logic [IW-1:0] mie_i, mip_i;
    logic [DW-1:0] mtvec_i, mepc_i;
    logic          flush_o;
    logic [DW-1:0] new_pc_o;
    logic          cause_we_o;
    logic [DW-1:0] cause_o;
    logic          epc_we_o;
    logic [DW-1:0] epc_o;
    logic          tval_we_o;
    logic [DW-1:0] tval_o;
    logic          mstatus_ie_clear_o, mstatus_ie_set_o;
    trap_state_t   dbg_state_o;

    obs_t          exp_q[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] last_cause = '0, last_epc = '0, last_tval = '0;

    always #5 clk = ~clk;

    trap_ctrl #(
        .DATA_WIDTH    (DW),
        .NUM_LOCAL_IRQ (NL),
        .FLUSH_HOLD    (FH)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .commit_valid_i     (commit_valid_i),
        .pc_i               (pc_i),
        .exc_valid_i        (exc_valid_i),
        .exc_code_i         (exc_code_i),
        .exc_tval_i         (exc_tval_i),
        .mret_i             (mret_i),
        .mstatus_mie_i      (mstatus_mie_i),
        .mie_i              (mie_i),
        .mip_i              (mip_i),
        .mtvec_i            (mtvec_i),
        .mepc_i             (mepc_i),
        .flush_o            (flush_o),
        .new_pc_o           (new_pc_o),
        .cause_we_o         (cause_we_o),
        .cause_o            (cause_o),
        .epc_we_o           (epc_we_o),
        .epc_o              (epc_o),
        .tval_we_o          (tval_we_o),
        .tval_o             (tval_o),
        .mstatus_ie_clear_o (mstatus_ie_clear_o),
        .mstatus_ie_set_o   (mstatus_ie_set_o),
        .dbg_state_o        (dbg_state_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic model_any(input logic [IW-1:0] p);
        return p[11] | p[3] | p[7] | (|p[IW-1:16]);
    endfunction

    function automatic logic [4:0] model_prio(input logic [IW-1:0] p);
        if (p[11]) return 5'd11;
        if (p[3])  return 5'd3;
        if (p[7])  return 5'd7;
        for (int i = 16; i < IW; i++) if (p[i]) return 5'(i);
        return 5'd0;
    endfunction

    function automatic logic [DW-1:0] model_target(input logic [DW-1:0] tvec, input logic intr,
                                                   input logic [4:0] c);
        logic [DW-1:0] base;
        base = {tvec[DW-1:2], 2'b00};
        if (tvec[1:0] == 2'b01 && intr) return base + {25'd0, c, 2'b00};
        return base;
    endfunction

    function automatic obs_t sample_obs();
        obs_t o;
        o.flush    = flush_o;
        o.new_pc   = new_pc_o;
        o.cause_we = cause_we_o;
        o.cause    = cause_o;
        o.epc_we   = epc_we_o;
        o.epc      = epc_o;
        o.tval_we  = tval_we_o;
        o.tval     = tval_o;
        o.ie_clear = mstatus_ie_clear_o;
        o.ie_set   = mstatus_ie_set_o;
        return o;
    endfunction

    task automatic push_trap(input logic [DW-1:0] tgt, input logic intr, input logic [4:0] c,
                             input logic [DW-1:0] epc, input logic [DW-1:0] tval);
        obs_t o;
        o          = '0;
        o.flush    = 1'b1;
        o.new_pc   = tgt;
        o.cause_we = 1'b1;
        o.cause    = {intr, 26'd0, c};
        o.epc_we   = 1'b1;
        o.epc      = epc;
        o.tval_we  = 1'b1;
        o.tval     = tval;
        o.ie_clear = 1'b1;
        exp_q.push_back(o);
        last_cause = o.cause;
        last_epc   = epc;
        last_tval  = tval;
    endtask

    task automatic push_mret(input logic [DW-1:0] mepc);
        obs_t o;
        o        = '0;
        o.flush  = 1'b1;
        o.new_pc = {mepc[DW-1:2], 2'b00};
        o.cause  = last_cause;
        o.epc    = last_epc;
        o.tval   = last_tval;
        o.ie_set = 1'b1;
        exp_q.push_back(o);
    endtask

    // ---------------- drivers ----------------
    task automatic clear_stim();
        commit_valid_i = 1'b0;
        pc_i           = '0;
        exc_valid_i    = 1'b0;
        exc_code_i     = '0;
        exc_tval_i     = '0;
        mret_i         = 1'b0;
        mie_i          = '0;
        mip_i          = '0;
    endtask

    task automatic offer_irq(input logic [IW-1:0] bits, input logic [DW-1:0] pc);
        mstatus_mie_i  = 1'b1;
        mie_i          = bits;
        mip_i          = bits;
        pc_i           = pc;
        commit_valid_i = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t got;
        rst_i         = 1'b0;
        mstatus_mie_i = 1'b0;
        mtvec_i       = '0;
        mepc_i        = '0;
        clear_stim();
        repeat (4) @(negedge clk);
        got = sample_obs();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        n_cmp++;
        if (dbg_state_o !== ST_OPERATING) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state_o, ST_OPERATING);
        end
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        got = sample_obs();
        n_cmp++;
        if (got !== obs_t'(0)) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h want 0", got);
        end
    endtask

    task automatic test_vectored_irq();
        obs_t got, exp;
        @(negedge clk);
        mtvec_i = 32'h8000_0001;
        offer_irq(32'h0000_0080, 32'h0000_0100);
        push_trap(32'h8000_001C, 1'b1, 5'd7, 32'h0000_0100, 32'h0);
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL vectored_irq: got %h want %h", got, exp);
        end
        clear_stim();
        @(negedge clk);
        n_cmp++;
        if (flush_o !== 1'b0 || dbg_state_o !== ST_HOLD) begin
            n_fail++;
            $display("FAIL single_cycle_strobe: flush %b state %0d want 0/%0d",
                     flush_o, dbg_state_o, ST_HOLD);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        obs_t got, exp;
        @(negedge clk);
        mtvec_i = 32'h0000_1000;
        offer_irq(32'h0004_0808, 32'h0000_0110);
        push_trap(32'h0000_1000, 1'b1, 5'd11, 32'h0000_0110, 32'h0);
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL prio_mei: got %h want %h", got, exp);
        end
        clear_stim();
        repeat (3) @(negedge clk);
        mtvec_i = 32'h0000_1001;
        offer_irq(32'h0012_0020, 32'h0000_0120);
        push_trap(32'h0000_1044, 1'b1, 5'd17, 32'h0000_0120, 32'h0);
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL prio_local17: got %h want %h", got, exp);
        end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_exc_over_irq();
        obs_t got, exp;
        @(negedge clk);
        mtvec_i = 32'h8000_0001;
        offer_irq(32'h0000_0800, 32'h0000_0300);
        exc_valid_i = 1'b1;
        exc_code_i  = 4'd2;
        exc_tval_i  = 32'hDEAD_BEEF;
        push_trap(32'h8000_0000, 1'b0, 5'd2, 32'h0000_0300, 32'hDEAD_BEEF);
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL exc_over_irq: got %h want %h", got, exp);
        end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bubble();
        obs_t got, exp;
        @(negedge clk);
        mtvec_i = 32'h0000_2000;
        offer_irq(32'h0000_0008, 32'h0000_0200);
        commit_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (flush_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bubble_no_flush[%0d]: got %b want 0", i, flush_o);
            end
        end
        commit_valid_i = 1'b1;
        push_trap(32'h0000_2000, 1'b1, 5'd3, 32'h0000_0200, 32'h0);
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL bubble_take: got %h want %h", got, exp);
        end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mret_hold();
        obs_t got, exp;
        @(negedge clk);
        mepc_i         = 32'h0000_0204;
        mret_i         = 1'b1;
        pc_i           = 32'h0000_0250;
        commit_valid_i = 1'b1;
        push_mret(32'h0000_0204);
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL mret_redirect: got %h want %h", got, exp);
        end
        clear_stim();
        @(negedge clk);
        exc_valid_i    = 1'b1;
        exc_code_i     = 4'd11;
        pc_i           = 32'h0000_0208;
        commit_valid_i = 1'b1;
        push_trap(32'h0000_2000, 1'b0, 5'd11, 32'h0000_0208, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (flush_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_ignores_ecall[%0d]: got %b want 0", i, flush_o);
            end
        end
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ecall_after_hold: got %h want %h", got, exp);
        end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_irq_over_mret();
        obs_t got, exp;
        @(negedge clk);
        mtvec_i = 32'h0000_3001;
        mepc_i  = 32'h0000_0999;
        offer_irq(32'h0001_0000, 32'h0000_0600);
        mret_i = 1'b1;
        push_trap(32'h0000_3040, 1'b1, 5'd16, 32'h0000_0600, 32'h0);
        @(negedge clk);
        got = sample_obs();
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL irq_over_mret: got %h want %h", got, exp);
        end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_no_trap();
        @(negedge clk);
        offer_irq(32'h0000_0008, 32'h0000_0700);
        commit_valid_i = 1'b0;
        @(negedge clk);
        mip_i          = '0;
        commit_valid_i = 1'b1;
        @(negedge clk);
        mie_i = 32'h0000_F777;
        mip_i = 32'h0000_F777;
        @(negedge clk);
        n_cmp++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_irq: got %b want 0", flush_o);
        end
        mstatus_mie_i = 1'b0;
        mie_i         = 32'h0000_0800;
        mip_i         = 32'h0000_0800;
        @(negedge clk);
        n_cmp++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reserved_bits_ignored: got %b want 0", flush_o);
        end
        @(negedge clk);
        n_cmp++;
        if (flush_o !== 1'b0 || epc_o !== last_epc || cause_o !== last_cause) begin
            n_fail++;
            $display("FAIL mie_off_hold: flush %b epc %h cause %h want 0 %h %h",
                     flush_o, epc_o, cause_o, last_epc, last_cause);
        end
        clear_stim();
        mstatus_mie_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        obs_t          got, exp;
        logic [IW-1:0] mie_v, mip_v;
        logic [DW-1:0] pc_v, tvec_v;
        logic [4:0]    c;
        int            kind, b;
        for (int it = 0; it < 24; it++) begin
            @(negedge clk);
            kind    = $urandom_range(0, 2);
            pc_v    = $urandom();
            tvec_v  = $urandom();
            mie_v   = $urandom();
            mip_v   = $urandom();
            mtvec_i = tvec_v;
            pc_i    = pc_v;
            commit_valid_i = 1'b1;
            if (kind == 0) begin
                mstatus_mie_i = 1'($urandom_range(0, 1));
                mie_i         = mie_v;
                mip_i         = mip_v;
                exc_valid_i   = 1'b1;
                exc_code_i    = 4'($urandom_range(0, 15));
                exc_tval_i    = $urandom();
                mret_i        = 1'($urandom_range(0, 1));
                push_trap(model_target(tvec_v, 1'b0, {1'b0, exc_code_i}), 1'b0,
                          {1'b0, exc_code_i}, pc_v, exc_tval_i);
            end else if (kind == 1) begin
                if (!model_any(mie_v & mip_v)) begin
                    b        = 16 + $urandom_range(0, NL - 1);
                    mie_v[b] = 1'b1;
                    mip_v[b] = 1'b1;
                end
                mstatus_mie_i = 1'b1;
                mie_i         = mie_v;
                mip_i         = mip_v;
                mret_i        = 1'($urandom_range(0, 1));
                c             = model_prio(mie_v & mip_v);
                push_trap(model_target(tvec_v, 1'b1, c), 1'b1, c, pc_v, 32'h0);
            end else begin
                mstatus_mie_i = 1'b0;
                mie_i         = mie_v;
                mip_i         = mip_v;
                mepc_i        = $urandom();
                mret_i        = 1'b1;
                push_mret(mepc_i);
            end
            @(negedge clk);
            got = sample_obs();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b[%0d] kind %0d: got %h want %h", it, kind, got, exp);
            end
            clear_stim();
            mstatus_mie_i = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (flush_o !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_gap[%0d]: got %b want 0", it, flush_o);
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        obs_t got;
        @(negedge clk);
        mtvec_i        = 32'h0000_4000;
        exc_valid_i    = 1'b1;
        exc_code_i     = 4'd3;
        pc_i           = 32'h0000_0800;
        commit_valid_i = 1'b1;
        @(negedge clk);
        clear_stim();
        n_cmp++;
        if (flush_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_setup: flush got %b want 1", flush_o);
        end
        #2 rst_i = 1'b0;
        #1;
        got = sample_obs();
        n_cmp++;
        if (got !== obs_t'(0) || dbg_state_o !== ST_OPERATING) begin
            n_fail++;
            $display("FAIL async_rst_mid_trap: got %h state %0d want 0/%0d",
                     got, dbg_state_o, ST_OPERATING);
        end
        last_cause = '0;
        last_epc   = '0;
        last_tval  = '0;
        @(negedge clk);
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectored_irq();
        test_priority();
        test_exc_over_irq();
        test_bubble();
        test_mret_hold();
        test_irq_over_mret();
        test_no_trap();
        test_back_to_back();
        test_async_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
